// File: rtl/alu_flag_psr.sv
// alu_flag_psr: processor status register behind the 16-bit ALU.
// Latches the ALU flags {N,Z,F,L,C}, evaluates the 4-bit branch condition
// for the branch/jump unit and keeps a small LIFO of flag sets for
// interrupt entry (push) and return (pop).
// Optional build macro ALU_FLAG_BYPASS_EN: when defined, condTrue is
// evaluated on the incoming ALU flags during a flag write, so a branch can
// directly follow a compare. The psr register timing is the same either way.
module alu_flag_psr #(
    parameter int STACK_DEPTH = 4,  // saved flag sets, power of two, >= 2
    parameter int PTR_W       = 3   // log2(STACK_DEPTH)+1
) (
    input  logic       clk,
    input  logic       reset,       // synchronous, active-low
    input  logic       flagWrite,
    input  logic       C_in,
    input  logic       L_in,
    input  logic       F_in,
    input  logic       Z_in,
    input  logic       N_in,
    input  logic [3:0] cond,
    input  logic       push,
    input  logic       pop,
    output logic       condTrue,
    output logic [4:0] psr,         // {N,Z,F,L,C}
    output logic       stackEmpty,
    output logic       stackFull,
    output logic       stackErr
);

    // Bit positions inside a flag set {N,Z,F,L,C}.
    localparam int C_B = 0;
    localparam int L_B = 1;
    localparam int F_B = 2;
    localparam int Z_B = 3;
    localparam int N_B = 4;

    // The pointer carries one extra bit so "full" (sp == STACK_DEPTH) is
    // distinguishable from "empty"; the low bits address the storage.
    localparam int               IDX_W   = PTR_W - 1;
    localparam logic [PTR_W-1:0] FULL_SP = PTR_W'(STACK_DEPTH);
    localparam logic [PTR_W-1:0] ONE_SP  = PTR_W'(1);

    logic [PTR_W-1:0] sp;
    logic [PTR_W-1:0] sp_dec;
    logic [4:0]       stack_mem [STACK_DEPTH];
    logic [4:0]       flags_in;
    logic [4:0]       eval_flags;
    logic [IDX_W-1:0] push_idx;
    logic [IDX_W-1:0] pop_idx;
    logic             do_push;
    logic             do_pop;
    logic             bad_op;

    assign flags_in   = {N_in, Z_in, F_in, L_in, C_in};
    assign stackEmpty = (sp == '0);
    assign stackFull  = (sp == FULL_SP);
    assign sp_dec     = sp - ONE_SP;
    assign push_idx   = sp[IDX_W-1:0];
    assign pop_idx    = sp_dec[IDX_W-1:0];

    // Simultaneous push and pop cancel out; only a lone request touches the stack.
    assign do_push = push & ~pop & ~stackFull;
    assign do_pop  = pop & ~push & ~stackEmpty;
    assign bad_op  = (push & ~pop & stackFull) | (pop & ~push & stackEmpty);

    // Status register, stack pointer and sticky error; reset wins over everything.
    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignments so every
        // right-hand side sees the pre-edge values (push saves the old psr).
        if (!reset) begin
            psr      <= '0;
            sp       <= '0;
            stackErr <= 1'b0;
        end else begin
            if (do_pop)
                psr <= stack_mem[pop_idx];
            else if (flagWrite)
                psr <= flags_in;

            if (do_push)
                sp <= sp + ONE_SP;
            else if (do_pop)
                sp <= sp_dec;

            if (bad_op)
                stackErr <= 1'b1;
        end
    end

    // Saved flag storage; writes the pre-update psr on interrupt entry.
    always_ff @(posedge clk) begin
        // NOTE: the storage has no reset on purpose; entries above sp are
        // never read, so clearing sp alone discards everything saved.
        if (do_push)
            stack_mem[push_idx] <= psr;
    end

    // Branch condition select, from the registered flags (or forwarded ones).
    always_comb begin
        // NOTE: every output of this block gets a default first so no
        // path through the case can infer a latch.
        eval_flags = psr;
`ifdef ALU_FLAG_BYPASS_EN
        if (flagWrite)
            eval_flags = flags_in;
`endif
        condTrue = 1'b0;
        case (cond)
            4'b0000: condTrue =  eval_flags[Z_B];                      // EQ
            4'b0001: condTrue = ~eval_flags[Z_B];                      // NE
            4'b0010: condTrue =  eval_flags[C_B];                      // CS
            4'b0011: condTrue = ~eval_flags[C_B];                      // CC
            4'b0100: condTrue =  eval_flags[L_B];                      // HI
            4'b0101: condTrue = ~eval_flags[L_B];                      // LS
            4'b0110: condTrue =  eval_flags[N_B];                      // GT
            4'b0111: condTrue = ~eval_flags[N_B];                      // LE
            4'b1000: condTrue =  eval_flags[F_B];                      // FS
            4'b1001: condTrue = ~eval_flags[F_B];                      // FC
            4'b1010: condTrue = ~eval_flags[L_B] & ~eval_flags[Z_B];   // LO
            4'b1011: condTrue =  eval_flags[L_B] |  eval_flags[Z_B];   // HS
            4'b1100: condTrue = ~eval_flags[N_B] & ~eval_flags[Z_B];   // LT
            4'b1101: condTrue =  eval_flags[N_B] |  eval_flags[Z_B];   // GE
            4'b1110: condTrue = 1'b1;                                  // UC
            default: condTrue = 1'b0;                                  // never
        endcase
    end

endmodule

// File: tb/tb_alu_flag_psr.sv
// Bench for alu_flag_psr: directed vectors with hand-computed expectations.
// Stimulus pushes the expected outputs of each cycle into a scoreboard
// queue; an independent monitor pops and compares on the falling edge.
// Expected vector layout: {psr[4:0], stackEmpty, stackFull, stackErr, condTrue}.
module tb_alu_flag_psr;

    logic       clk;
    logic       reset;
    logic       flagWrite;
    logic       C_in, L_in, F_in, Z_in, N_in;
    logic [3:0] cond;
    logic       push;
    logic       pop;
    logic       condTrue;
    logic [4:0] psr;
    logic       stackEmpty;
    logic       stackFull;
    logic       stackErr;

`ifdef ALU_FLAG_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    typedef struct {
        int         cyc;
        string      name;
        logic [8:0] exp;
    } exp_t;

    exp_t sb[$];
    int   cyc  = 0;
    bit   done = 1'b0;

    alu_flag_psr #(.STACK_DEPTH(4), .PTR_W(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .flagWrite (flagWrite),
        .C_in      (C_in),
        .L_in      (L_in),
        .F_in      (F_in),
        .Z_in      (Z_in),
        .N_in      (N_in),
        .cond      (cond),
        .push      (push),
        .pop       (pop),
        .condTrue  (condTrue),
        .psr       (psr),
        .stackEmpty(stackEmpty),
        .stackFull (stackFull),
        .stackErr  (stackErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Apply one cycle of inputs; fl is {N,Z,F,L,C}.
    task automatic drive(input logic fw, input logic [4:0] fl,
                         input logic pu, input logic po, input logic [3:0] cd);
        flagWrite = fw;
        {N_in, Z_in, F_in, L_in, C_in} = fl;
        push = pu;
        pop  = po;
        cond = cd;
    endtask

    // Expected outputs for the current cycle.
    task automatic want(input string nm, input logic [4:0] p, input logic e,
                        input logic f, input logic er, input logic ct);
        exp_t item;
        item.cyc  = cyc;
        item.name = nm;
        item.exp  = {p, e, f, er, ct};
        sb.push_back(item);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every scoreboard entry due this cycle, then summarises.
    initial begin
        int passed = 0;
        int total  = 0;
        exp_t e;
        logic [8:0] act;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc == cyc) begin
                e   = sb.pop_front();
                act = {psr, stackEmpty, stackFull, stackErr, condTrue};
                total++;
                if (act === e.exp)
                    passed++;
                else
                    $display("FAIL %s: got psr=%b empty=%b full=%b err=%b condTrue=%b, want psr=%b empty=%b full=%b err=%b condTrue=%b",
                             e.name, act[8:4], act[3], act[2], act[1], act[0],
                             e.exp[8:4], e.exp[3], e.exp[2], e.exp[1], e.exp[0]);
            end
            if (done) begin
                total++;
                if (sb.size() == 0)
                    passed++;
                else
                    $display("FAIL pending: got %0d unchecked entries, want 0", sb.size());
                $display("%0d/%0d checks passed", passed, total);
                $finish;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    // Stimulus: each cycle sets inputs, records what the outputs must show
    // now (state after the previous edge), then advances one clock.
    initial begin
        reset = 1'b0;
        drive(1'b0, 5'b00000, 1'b0, 1'b0, 4'b1110);
        tick(); tick();

        // Reset state, UC and never conditions.
        want("rst_uc", 5'b00000, 1, 0, 0, 1); tick();
        reset = 1'b1;
        drive(1'b0, 5'b00000, 1'b0, 1'b0, 4'b1111);
        want("rst_nv", 5'b00000, 1, 0, 0, 0); tick();

        // CMP 3,3: Z only. Same-cycle EQ depends on forwarding.
        drive(1'b1, 5'b01000, 1'b0, 1'b0, 4'b0000);
        want("byp_same", 5'b00000, 1, 0, 0, BYP); tick();
        drive(1'b0, 5'b00000, 1'b0, 1'b0, 4'b0000);
        want("eq", 5'b01000, 1, 0, 0, 1); tick();
        drive(1'b0, 5'b00000, 1'b0, 1'b0, 4'b0001);
        want("ne", 5'b01000, 1, 0, 0, 0); tick();
        drive(1'b0, 5'b00000, 1'b0, 1'b0, 4'b1101);
        want("ge", 5'b01000, 1, 0, 0, 1); tick();

        // CMP 2,3: L only.
        drive(1'b1, 5'b00010, 1'b0, 1'b0, 4'b1110);
        want("z_hold", 5'b01000, 1, 0, 0, 1); tick();
        drive(1'b0, 5'b00000, 1'b0, 1'b0, 4'b0100);
        want("hi", 5'b00010, 1, 0, 0, 1); tick();
        drive(1'b0, 5'b00000, 1'b0, 1'b0, 4'b1010);
        want("lo", 5'b00010, 1, 0, 0, 0); tick();

        // Back to Z, then push with a same-cycle flag write, then pop.
        drive(1'b1, 5'b01000, 1'b0, 1'b0, 4'b1110);
        want("l_hold", 5'b00010, 1, 0, 0, 1); tick();
        drive(1'b1, 5'b10000, 1'b1, 1'b0, 4'b1110);
        want("pre_push", 5'b01000, 1, 0, 0, 1); tick();
        drive(1'b0, 5'b00000, 1'b0, 1'b1, 4'b0110);
        want("push_fw", 5'b10000, 0, 0, 0, 1); tick();
        drive(1'b0, 5'b00000, 1'b0, 1'b0, 4'b0000);
        want("pop", 5'b01000, 1, 0, 0, 1); tick();

        // Fill the stack with distinct flag sets, then overflow once.
        drive(1'b1, 5'b00001, 1'b1, 1'b0, 4'b1110); tick();
        drive(1'b1, 5'b00010, 1'b1, 1'b0, 4'b1110);
        want("push1", 5'b00001, 0, 0, 0, 1); tick();
        drive(1'b1, 5'b00100, 1'b1, 1'b0, 4'b1110);
        want("push2", 5'b00010, 0, 0, 0, 1); tick();
        drive(1'b1, 5'b10000, 1'b1, 1'b0, 4'b1110);
        want("push3", 5'b00100, 0, 0, 0, 1); tick();
        drive(1'b0, 5'b00000, 1'b1, 1'b0, 4'b1110);
        want("push4", 5'b10000, 0, 1, 0, 1); tick();
        // First pop also carries a flag write, which the pop must override.
        drive(1'b1, 5'b11111, 1'b0, 1'b1, 4'b1110);
        want("push5", 5'b10000, 0, 1, 1, 1); tick();

        // Unwind in LIFO order, then underflow.
        drive(1'b0, 5'b00000, 1'b0, 1'b1, 4'b1110);
        want("pop1", 5'b00100, 0, 0, 1, 1); tick();
        want("pop2", 5'b00010, 0, 0, 1, 1); tick();
        want("pop3", 5'b00001, 0, 0, 1, 1); tick();
        want("pop4", 5'b01000, 1, 0, 1, 1); tick();
        drive(1'b1, 5'b00011, 1'b0, 1'b1, 4'b1110);
        want("pop_empty", 5'b01000, 1, 0, 1, 1); tick();
        drive(1'b0, 5'b00000, 1'b1, 1'b0, 4'b1110);
        want("pop_empty_fw", 5'b00011, 1, 0, 1, 1); tick();

        // push and pop together: stack untouched, flag write applies.
        drive(1'b1, 5'b00001, 1'b1, 1'b1, 4'b1110);
        want("push_only", 5'b00011, 0, 0, 1, 1); tick();
        drive(1'b0, 5'b00000, 1'b0, 1'b1, 4'b1110);
        want("both", 5'b00001, 0, 0, 1, 1); tick();
        drive(1'b0, 5'b00000, 1'b1, 1'b0, 4'b1110);
        want("both_pop", 5'b00011, 1, 0, 1, 1); tick();
        tick(); tick();

        // Reset with sp=3 and competing requests: reset wins.
        reset = 1'b0;
        drive(1'b1, 5'b11111, 1'b1, 1'b0, 4'b1110);
        want("sp3", 5'b00011, 0, 0, 1, 1); tick();
        reset = 1'b1;
        drive(1'b0, 5'b00000, 1'b0, 1'b1, 4'b1110);
        want("mid_rst", 5'b00000, 1, 0, 0, 1); tick();
        drive(1'b0, 5'b00000, 1'b0, 1'b0, 4'b1110);
        want("rst_pop_err", 5'b00000, 1, 0, 1, 1); tick();

        done = 1'b1;
    end

endmodule
